player_mover: RTL and testbench

- Owns the player (Chun-Yi) position registers pos_h_CY / pos_v_CY.
- Consumes the 4-bit collision flags produced by the wall collision checkers.
- Steps the player one pixel per movement tick in the highest-priority pressed direction, unless that direction is blocked by a wall or the screen boundary.
- Position outputs feed back into the wall checkers and into the sprite renderer.

---
 rtl/player_mover.sv | 156 +++++++++++++++
 tb/tb_player_mover.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_mover.sv
// player_mover: owns the player's position, stepping one pixel per movement
// tick in the highest-priority pressed direction unless a wall or the
// screen edge is in the way.
module player_mover #(
    parameter int TICK_DIV = 500000,
    parameter int START_H  = 320,
    parameter int START_V  = 240,
    parameter int H_MAX    = 620,
    parameter int V_MAX    = 460
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic [3:0] collision,
    input  logic       respawn,
    output logic [9:0] pos_h_CY,
    output logic [9:0] pos_v_CY,
    output logic [1:0] facing,
    output logic       moving,
    output logic       step_pulse
);

    localparam int              CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [9:0]      H_LIM    = 10'(H_MAX);
    localparam logic [9:0]      V_LIM    = 10'(V_MAX);
    localparam logic [9:0]      H_START  = 10'(START_H);
    localparam logic [9:0]      V_START  = 10'(START_V);

    // Direction codes double as the facing output encoding.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WALK    = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          tick;
    dir_t          dir;
    logic          dir_vld;
    logic          blocked;
    logic [9:0]    pos_h_nxt, pos_v_nxt;
    logic [1:0]    facing_nxt;
    logic          step_nxt;

    assign tick   = (cnt == CNT_LAST);
    assign moving = (state == WALK);

    // Movement tick divider; respawn restarts the tick phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (respawn || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Fixed-priority direction pick: up > down > left > right.
    always_comb begin
        dir     = DIR_UP;
        dir_vld = 1'b1;
        if (key_up)
            dir = DIR_UP;
        else if (key_down)
            dir = DIR_DOWN;
        else if (key_left)
            dir = DIR_LEFT;
        else if (key_right)
            dir = DIR_RIGHT;
        else
            dir_vld = 1'b0;
    end

    // A direction is blocked by its wall flag or by the screen edge, so
    // positions never wrap below 0 or past the maximum.
    always_comb begin
        blocked = 1'b0;
        case (dir)
            DIR_UP:    blocked = collision[3] || (pos_v_CY == 10'd0);
            DIR_DOWN:  blocked = collision[2] || (pos_v_CY == V_LIM);
            DIR_LEFT:  blocked = collision[0] || (pos_h_CY == 10'd0);
            DIR_RIGHT: blocked = collision[1] || (pos_h_CY == H_LIM);
            default:   blocked = 1'b0;
        endcase
    end

    // Next-state / next-position logic; only a tick can change anything,
    // and respawn overrides the tick.
    always_comb begin
        state_nxt  = state;
        pos_h_nxt  = pos_h_CY;
        pos_v_nxt  = pos_v_CY;
        facing_nxt = facing;
        step_nxt   = 1'b0;
        if (respawn) begin
            state_nxt  = IDLE;
            pos_h_nxt  = H_START;
            pos_v_nxt  = V_START;
            facing_nxt = DIR_DOWN;
        end else if (tick) begin
            if (!dir_vld) begin
                state_nxt = IDLE;
            end else if (blocked) begin
                state_nxt  = BLOCKED;
                facing_nxt = dir;
            end else begin
                state_nxt  = WALK;
                facing_nxt = dir;
                step_nxt   = 1'b1;
                case (dir)
                    DIR_UP:    pos_v_nxt = pos_v_CY - 10'd1;
                    DIR_DOWN:  pos_v_nxt = pos_v_CY + 10'd1;
                    DIR_LEFT:  pos_h_nxt = pos_h_CY - 10'd1;
                    DIR_RIGHT: pos_h_nxt = pos_h_CY + 10'd1;
                    default:   ;
                endcase
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Position, facing and step pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_h_CY   <= H_START;
            pos_v_CY   <= V_START;
            facing     <= DIR_DOWN;
            step_pulse <= 1'b0;
        end else begin
            pos_h_CY   <= pos_h_nxt;
            pos_v_CY   <= pos_v_nxt;
            facing     <= facing_nxt;
            step_pulse <= step_nxt;
        end
    end

endmodule

// File: tb/tb_player_mover.sv
// Randomised and directed bench for player_mover. Two instances share the
// inputs: one at the default start, one starting next to the top/right edges.
module tb_player_mover;

    localparam int TD = 4;
    localparam int HM = 620;
    localparam int VM = 460;

    logic       clk = 1'b0;
    logic       rst, key_up, key_down, key_left, key_right, respawn;
    logic [3:0] collision;
    logic [9:0] a_h, a_v, b_h, b_v;
    logic [1:0] a_f, b_f;
    logic       a_mv, b_mv, a_sp, b_sp;

    always #5 clk = ~clk;

    player_mover #(.TICK_DIV(TD)) dut_a (
        .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down),
        .key_left(key_left), .key_right(key_right), .collision(collision),
        .respawn(respawn), .pos_h_CY(a_h), .pos_v_CY(a_v), .facing(a_f),
        .moving(a_mv), .step_pulse(a_sp)
    );

    player_mover #(.TICK_DIV(TD), .START_H(618), .START_V(1)) dut_b (
        .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down),
        .key_left(key_left), .key_right(key_right), .collision(collision),
        .respawn(respawn), .pos_h_CY(b_h), .pos_v_CY(b_v), .facing(b_f),
        .moving(b_mv), .step_pulse(b_sp)
    );

    // Reference model: player state plus edges elapsed since (re)start.
    typedef struct {
        int h; int v; int f; int mv; int sp; int k;
    } m_t;

    m_t ma, mb;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic m_t m_reset(input int sh, input int sv);
        m_t n;
        n.h = sh; n.v = sv; n.f = 1; n.mv = 0; n.sp = 0; n.k = 0;
        return n;
    endfunction

    // One clock edge of the player: every TD-th edge is a movement tick.
    function automatic m_t m_next(input m_t m, input int sh, input int sv);
        m_t n;
        int d, dh, dv, cb, nh, nv;
        logic [3:0] kb;
        if (respawn) return m_reset(sh, sv);
        n = m;
        n.sp = 0;
        n.k = m.k + 1;
        if (n.k % TD != 0) return n;
        kb = {key_right, key_left, key_down, key_up};
        d = -1;
        for (int i = 3; i >= 0; i--) if (kb[i]) d = i;
        if (d < 0) begin
            n.mv = 0;
            return n;
        end
        dh = 0; dv = 0; cb = 0;
        case (d)
            0: begin dv = -1; cb = 3; end
            1: begin dv =  1; cb = 2; end
            2: begin dh = -1; cb = 0; end
            default: begin dh = 1; cb = 1; end
        endcase
        n.f = d;
        nh = m.h + dh;
        nv = m.v + dv;
        if (collision[cb] || nh < 0 || nh > HM || nv < 0 || nv > VM) begin
            n.mv = 0;
        end else begin
            n.h = nh; n.v = nv; n.mv = 1; n.sp = 1;
        end
        return n;
    endfunction

    task automatic check_all(input string ph);
        chk({ph, ".a_h"},  int'(a_h),  ma.h);
        chk({ph, ".a_v"},  int'(a_v),  ma.v);
        chk({ph, ".a_f"},  int'(a_f),  ma.f);
        chk({ph, ".a_mv"}, int'(a_mv), ma.mv);
        chk({ph, ".a_sp"}, int'(a_sp), ma.sp);
        chk({ph, ".b_h"},  int'(b_h),  mb.h);
        chk({ph, ".b_v"},  int'(b_v),  mb.v);
        chk({ph, ".b_f"},  int'(b_f),  mb.f);
        chk({ph, ".b_mv"}, int'(b_mv), mb.mv);
        chk({ph, ".b_sp"}, int'(b_sp), mb.sp);
    endtask

    // Advance one edge in model and DUT, then compare just after the edge.
    task automatic step(input string ph);
        @(posedge clk);
        if (rst) begin
            ma = m_reset(320, 240);
            mb = m_reset(618, 1);
        end else begin
            ma = m_next(ma, 320, 240);
            mb = m_next(mb, 618, 1);
        end
        #1 check_all(ph);
    endtask

    task automatic run(input string ph, input int n);
        repeat (n) step(ph);
    endtask

    task automatic keys(input logic u, input logic d, input logic l, input logic r);
        key_up = u; key_down = d; key_left = l; key_right = r;
    endtask

    task automatic do_respawn();
        respawn = 1'b1;
        step("respawn");
        respawn = 1'b0;
    endtask

    initial begin
        rst = 1'b0; respawn = 1'b0; collision = 4'b0;
        keys(0, 0, 0, 0);
        ma = m_reset(320, 240);
        mb = m_reset(618, 1);

        // Asynchronous reset, mid-cycle, checked before any clock edge.
        #12 rst = 1'b1;
        #1;
        chk("rst_async.h",  int'(a_h), 320);
        chk("rst_async.v",  int'(a_v), 240);
        chk("rst_async.f",  int'(a_f), 1);
        chk("rst_async.mv", int'(a_mv), 0);
        chk("rst_async.sp", int'(a_sp), 0);
        chk("rst_async.bh", int'(b_h), 618);
        step("rst");
        step("rst");
        rst = 1'b0;

        // Walk right for ten ticks; B hits the right edge and stays there.
        keys(0, 0, 0, 1);
        run("right", 40);
        chk("right.h",  int'(a_h), 330);
        chk("right.f",  int'(a_f), 3);
        chk("right.mv", int'(a_mv), 1);
        chk("right.bh", int'(b_h), 620);
        chk("right.bmv", int'(b_mv), 0);
        keys(0, 0, 0, 0);
        run("release", 4);
        chk("release.mv", int'(a_mv), 0);
        chk("release.h",  int'(a_h), 330);

        // Wall on the left blocks, then clears.
        do_respawn();
        keys(0, 0, 1, 0);
        collision = 4'b0001;
        run("leftwall", 12);
        chk("leftwall.h", int'(a_h), 320);
        chk("leftwall.f", int'(a_f), 2);
        collision = 4'b0000;
        run("leftfree", 4);
        chk("leftfree.h", int'(a_h), 319);

        // Up beats right; B reaches the top edge.
        do_respawn();
        keys(1, 0, 0, 1);
        run("upright", 12);
        chk("upright.v", int'(a_v), 237);
        chk("upright.h", int'(a_h), 320);
        chk("upright.bv", int'(b_v), 0);
        chk("upright.bf", int'(b_f), 0);

        // Left all the way to column 0.
        do_respawn();
        keys(0, 0, 1, 0);
        run("leftedge", TD * 325);
        chk("leftedge.h",  int'(a_h), 0);
        chk("leftedge.mv", int'(a_mv), 0);

        // Respawn on a tick cycle, then reset two clocks before a tick.
        do_respawn();
        keys(0, 1, 0, 0);
        run("down", 12);
        chk("down.v", int'(a_v), 243);
        run("down", 3);
        do_respawn();
        run("after_resp", 3);
        chk("after_resp.v", int'(a_v), 240);
        run("after_resp", 1);
        chk("after_resp.v1", int'(a_v), 241);
        run("pre_rst", 2);
        rst = 1'b1;
        #1 chk("mid_rst.v", int'(a_v), 240);
        step("mid_rst");
        rst = 1'b0;
        run("post_rst", 4);
        chk("post_rst.v", int'(a_v), 241);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) begin
                logic [3:0] kk;
                kk = 4'($urandom);
                keys(kk[0], kk[1], kk[2], kk[3]);
            end
            collision = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0;
            respawn   = ($urandom_range(63) == 0);
            rst       = ($urandom_range(199) == 0);
            step("rand");
        end
        rst = 1'b0; respawn = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
